// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch controller.
// Contents: True/False constants, load/store opcodes, default unit sizes,
// the flush duration, and helpers for classifying opcodes and sizing counters.
package dispatch_ctrl_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // RV32 major opcodes for loads and stores
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam int ROB_SIZE_DEF     = 16;
  localparam int RS_SIZE_DEF      = 16;
  localparam int LSB_SIZE_DEF     = 16;
  localparam int FLUSH_CYCLES_DEF = 2;

  // An instruction is routed to the load/store buffer when it is a load or a store
  function automatic logic is_lsb_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  // Bits needed to hold 0..max_val, never less than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dispatch_ctrl_credit_counter.sv
// Saturating credit counter for one back-end unit.
// Ports:
//   clk, rst      clock and synchronous active-low reset (count -> SIZE)
//   rdy           global enable; low holds the count
//   consume       take one credit (caller guarantees count > 0)
//   free          return one credit
//   restore       force the count back to SIZE; overrides consume/free
//   count         current number of free entries
//   zero          count == 0
//   overflow      a return arrived while already at SIZE (single-cycle pulse)
module credit_counter
  import dispatch_ctrl_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       consume,
  input  logic                       free,
  input  logic                       restore,
  output logic [cnt_width(SIZE)-1:0] count,
  output logic                       zero,
  output logic                       overflow
);

  localparam int W = cnt_width(SIZE);
  localparam logic [W-1:0] MAX = W'(SIZE);

  logic [W-1:0] count_r;
  logic         inc_s;
  logic         dec_s;

  // Decide the direction of change; a simultaneous take and return cancel out
  always_comb begin
    inc_s    = FALSE;
    dec_s    = FALSE;
    overflow = FALSE;
    if (rdy && !restore) begin
      if (consume && !free) begin
        dec_s = (count_r != {W{1'b0}});
      end else if (free && !consume) begin
        if (count_r == MAX) begin
          overflow = TRUE;
        end else begin
          inc_s = TRUE;
        end
      end else begin
        inc_s = FALSE;
      end
    end else begin
      overflow = FALSE;
    end
  end

  // Credit register: reset/restore to SIZE, otherwise saturating up/down
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= MAX;
    end else if (rdy && restore) begin
      count_r <= MAX;
    end else if (inc_s) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else if (dec_s) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: grants the instruction-queue head to the decoder when
// the ROB and the target unit (RS or LSB) have free entries, and blocks
// dispatch for a few cycles after a mispredict rollback.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   rdy                          global enable; low freezes all state
//   IQ_head_valid/IQ_head_opcode queue head presence and opcode
//   ID_ready                     decoder can accept
//   ROB_commit/RS_release/LSB_release  one entry freed in that unit
//   ROB_roll_back_flag           mispredict flush request
//   launch, launch_is_LSB        combinational grant and its target
//   ROB/RS/LSB_is_full           that unit has no credit left
//   flushing                     controller is in FLUSH
//   credit_err                   sticky: a release arrived at full credit
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int ROB_SIZE     = ROB_SIZE_DEF,
  parameter int RS_SIZE      = RS_SIZE_DEF,
  parameter int LSB_SIZE     = LSB_SIZE_DEF,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       IQ_head_valid,
  input  logic [6:0] IQ_head_opcode,
  input  logic       ID_ready,
  input  logic       ROB_commit,
  input  logic       RS_release,
  input  logic       LSB_release,
  input  logic       ROB_roll_back_flag,
  output logic       launch,
  output logic       launch_is_LSB,
  output logic       ROB_is_full,
  output logic       RS_is_full,
  output logic       LSB_is_full,
  output logic       flushing,
  output logic       credit_err
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int FW = cnt_width(FLUSH_CYCLES);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);

  state_t        state_r;
  logic [FW-1:0] flush_cnt_r;
  logic          credit_err_r;

  logic is_lsb_s;
  logic launch_s;
  logic run_s;
  logic rob_zero_s, rs_zero_s, lsb_zero_s;
  logic rob_ovf_s, rs_ovf_s, lsb_ovf_s;

  logic [cnt_width(ROB_SIZE)-1:0] rob_count_s;
  logic [cnt_width(RS_SIZE)-1:0]  rs_count_s;
  logic [cnt_width(LSB_SIZE)-1:0] lsb_count_s;

  // Releases count only in RUN with no rollback; a rollback restores anyway
  assign run_s = rdy && (state_r == ST_RUN) && !ROB_roll_back_flag;

  // Dispatch grant: all enables plus credit in the ROB and the target unit
  always_comb begin
    is_lsb_s = is_lsb_op(IQ_head_opcode);
    launch_s = FALSE;
    if (run_s && IQ_head_valid && ID_ready && !rob_zero_s) begin
      if (is_lsb_s) begin
        launch_s = !lsb_zero_s;
      end else begin
        launch_s = !rs_zero_s;
      end
    end else begin
      launch_s = FALSE;
    end
  end

  credit_counter #(.SIZE(ROB_SIZE)) u_rob (
    .clk(clk), .rst(rst), .rdy(rdy),
    .consume(launch_s), .free(ROB_commit && run_s), .restore(ROB_roll_back_flag),
    .count(rob_count_s), .zero(rob_zero_s), .overflow(rob_ovf_s)
  );

  credit_counter #(.SIZE(RS_SIZE)) u_rs (
    .clk(clk), .rst(rst), .rdy(rdy),
    .consume(launch_s && !is_lsb_s), .free(RS_release && run_s), .restore(ROB_roll_back_flag),
    .count(rs_count_s), .zero(rs_zero_s), .overflow(rs_ovf_s)
  );

  credit_counter #(.SIZE(LSB_SIZE)) u_lsb (
    .clk(clk), .rst(rst), .rdy(rdy),
    .consume(launch_s && is_lsb_s), .free(LSB_release && run_s), .restore(ROB_roll_back_flag),
    .count(lsb_count_s), .zero(lsb_zero_s), .overflow(lsb_ovf_s)
  );

  // Controller FSM: RUN/FLUSH sequencing, flush timer and sticky credit error
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_RUN;
      flush_cnt_r  <= {FW{1'b0}};
      credit_err_r <= FALSE;
    end else if (!rdy) begin
      state_r      <= state_r;
      flush_cnt_r  <= flush_cnt_r;
      credit_err_r <= credit_err_r;
    end else if (ROB_roll_back_flag) begin
      // entering or re-entering FLUSH restarts the full blocking window
      state_r     <= ST_FLUSH;
      flush_cnt_r <= FLUSH_LOAD;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (rob_ovf_s || rs_ovf_s || lsb_ovf_s) begin
            credit_err_r <= TRUE;
          end else begin
            credit_err_r <= credit_err_r;
          end
        end
        ST_FLUSH: begin
          // leave on the edge where the timer reaches zero
          if (flush_cnt_r <= FLUSH_ONE) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= {FW{1'b0}};
          end else begin
            flush_cnt_r <= flush_cnt_r - FLUSH_ONE;
          end
        end
        default: begin
          state_r     <= ST_RUN;
          flush_cnt_r <= {FW{1'b0}};
        end
      endcase
    end
  end

  assign launch        = launch_s;
  assign launch_is_LSB = launch_s && is_lsb_s;
  assign ROB_is_full   = rob_zero_s;
  assign RS_is_full    = rs_zero_s;
  assign LSB_is_full   = lsb_zero_s;
  assign flushing      = (state_r == ST_FLUSH);
  assign credit_err    = credit_err_r;

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rdy = 1'b1;
  logic       IQ_head_valid = 1'b0;
  logic [6:0] IQ_head_opcode = 7'h00;
  logic       ID_ready = 1'b0;
  logic       ROB_commit = 1'b0;
  logic       RS_release = 1'b0;
  logic       LSB_release = 1'b0;
  logic       ROB_roll_back_flag = 1'b0;
  logic       launch, launch_is_LSB, ROB_is_full, RS_is_full, LSB_is_full;
  logic       flushing, credit_err;

  int total = 0;
  int bad = 0;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  dispatch_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .IQ_head_valid(IQ_head_valid), .IQ_head_opcode(IQ_head_opcode),
    .ID_ready(ID_ready), .ROB_commit(ROB_commit), .RS_release(RS_release),
    .LSB_release(LSB_release), .ROB_roll_back_flag(ROB_roll_back_flag),
    .launch(launch), .launch_is_LSB(launch_is_LSB),
    .ROB_is_full(ROB_is_full), .RS_is_full(RS_is_full), .LSB_is_full(LSB_is_full),
    .flushing(flushing), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; IQ_head_valid = 1'b0; IQ_head_opcode = OP_ALU; ID_ready = 1'b0;
    ROB_commit = 1'b0; RS_release = 1'b0; LSB_release = 1'b0; ROB_roll_back_flag = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (launch !== 1'b0) begin bad++; $display("FAIL reset_launch got=%b exp=0", launch); end
    total++; if ({ROB_is_full, RS_is_full, LSB_is_full} !== 3'b000) begin bad++; $display("FAIL reset_full got=%b exp=000", {ROB_is_full, RS_is_full, LSB_is_full}); end
    total++; if (flushing !== 1'b0) begin bad++; $display("FAIL reset_flushing got=%b exp=0", flushing); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_credit_err got=%b exp=0", credit_err); end
    total++; if (dut.u_rs.count !== 5'd16) begin bad++; $display("FAIL reset_rs_count got=%0d exp=16", dut.u_rs.count); end
    // reset wins over rollback
    rst = 1'b0; ROB_roll_back_flag = 1'b1; tick(); tick();
    total++; if (flushing !== 1'b0) begin bad++; $display("FAIL reset_over_rollback got=%b exp=0", flushing); end
    ROB_roll_back_flag = 1'b0; rst = 1'b1;
  endtask

  // 16 ALU launches drain RS; ROB_commit alongside keeps ROB at 16
  task automatic test_rs_fill();
    do_reset();
    IQ_head_valid = 1'b1; IQ_head_opcode = OP_ALU; ID_ready = 1'b1; ROB_commit = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      total++; if (launch !== 1'b1 || launch_is_LSB !== 1'b0) begin bad++; $display("FAIL rs_fill_launch_%0d got=%b%b exp=10", i, launch, launch_is_LSB); end
      tick();
    end
    ROB_commit = 1'b0;
    #1;
    total++; if (RS_is_full !== 1'b1) begin bad++; $display("FAIL rs_full got=%b exp=1", RS_is_full); end
    total++; if (launch !== 1'b0) begin bad++; $display("FAIL rs_17th_launch got=%b exp=0", launch); end
    total++; if (dut.u_rob.count !== 5'd16) begin bad++; $display("FAIL rob_commit_cancel got=%0d exp=16", dut.u_rob.count); end
  endtask

  // With RS empty a load still dispatches to the LSB
  task automatic test_lsb_launch();
    IQ_head_opcode = OP_LOAD;
    #1;
    total++; if (launch !== 1'b1 || launch_is_LSB !== 1'b1) begin bad++; $display("FAIL lsb_launch got=%b%b exp=11", launch, launch_is_LSB); end
    tick();
    total++; if (dut.u_lsb.count !== 5'd15) begin bad++; $display("FAIL lsb_count got=%0d exp=15", dut.u_lsb.count); end
    total++; if (dut.u_rob.count !== 5'd15) begin bad++; $display("FAIL rob_after_load got=%0d exp=15", dut.u_rob.count); end
    IQ_head_opcode = OP_STORE;
    #1;
    total++; if (launch_is_LSB !== 1'b1) begin bad++; $display("FAIL store_is_lsb got=%b exp=1", launch_is_LSB); end
    IQ_head_valid = 1'b0;
    #1;
    total++; if (launch_is_LSB !== 1'b0) begin bad++; $display("FAIL lsb_flag_no_launch got=%b exp=0", launch_is_LSB); end
  endtask

  // Bring all credits to 3, rollback, then count blocked cycles
  task automatic test_rollback();
    do_reset();
    IQ_head_valid = 1'b1; IQ_head_opcode = OP_ALU; ID_ready = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    IQ_head_opcode = OP_LOAD; ROB_commit = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    ROB_commit = 1'b0; IQ_head_valid = 1'b0;
    total++; if ({dut.u_rob.count, dut.u_rs.count, dut.u_lsb.count} !== {5'd3, 5'd3, 5'd3}) begin bad++; $display("FAIL pre_rollback_counts got=%0d/%0d/%0d exp=3/3/3", dut.u_rob.count, dut.u_rs.count, dut.u_lsb.count); end
    IQ_head_valid = 1'b1; IQ_head_opcode = OP_ALU; ROB_roll_back_flag = 1'b1; RS_release = 1'b1;
    #1;
    total++; if (launch !== 1'b0) begin bad++; $display("FAIL rollback_cycle_launch got=%b exp=0", launch); end
    tick();
    ROB_roll_back_flag = 1'b0;
    total++; if (flushing !== 1'b1) begin bad++; $display("FAIL flush1_flushing got=%b exp=1", flushing); end
    total++; if ({dut.u_rob.count, dut.u_rs.count, dut.u_lsb.count} !== {5'd16, 5'd16, 5'd16}) begin bad++; $display("FAIL restore_counts got=%0d/%0d/%0d exp=16/16/16", dut.u_rob.count, dut.u_rs.count, dut.u_lsb.count); end
    total++; if (launch !== 1'b0) begin bad++; $display("FAIL flush1_launch got=%b exp=0", launch); end
    tick();
    RS_release = 1'b0;
    total++; if (flushing !== 1'b1 || launch !== 1'b0) begin bad++; $display("FAIL flush2 got=%b%b exp=10", flushing, launch); end
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL flush_release_ignored got=%b exp=0", credit_err); end
    tick();
    total++; if (flushing !== 1'b0 || launch !== 1'b1) begin bad++; $display("FAIL flush_exit got=%b%b exp=01", flushing, launch); end
    IQ_head_valid = 1'b0;
  endtask

  // A second rollback during FLUSH restarts the timer
  task automatic test_reload();
    do_reset();
    ROB_roll_back_flag = 1'b1; tick(); ROB_roll_back_flag = 1'b0;
    tick();
    total++; if (dut.flush_cnt_r !== 2'd1) begin bad++; $display("FAIL reload_pre got=%0d exp=1", dut.flush_cnt_r); end
    ROB_roll_back_flag = 1'b1; tick(); ROB_roll_back_flag = 1'b0;
    total++; if (dut.flush_cnt_r !== 2'd2 || flushing !== 1'b1) begin bad++; $display("FAIL reload_cnt got=%0d/%b exp=2/1", dut.flush_cnt_r, flushing); end
    tick(); tick();
    total++; if (flushing !== 1'b0) begin bad++; $display("FAIL reload_exit got=%b exp=0", flushing); end
  endtask

  // rdy low freezes timer, credits and FSM mid-flush, and in RUN
  task automatic test_rdy_freeze();
    do_reset();
    ROB_roll_back_flag = 1'b1; tick(); ROB_roll_back_flag = 1'b0;
    tick();
    rdy = 1'b0; IQ_head_valid = 1'b1; ID_ready = 1'b1; RS_release = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (dut.flush_cnt_r !== 2'd1 || flushing !== 1'b1 || launch !== 1'b0) begin bad++; $display("FAIL freeze_%0d got=%0d/%b/%b exp=1/1/0", i, dut.flush_cnt_r, flushing, launch); end
    end
    RS_release = 1'b0; rdy = 1'b1;
    tick();
    total++; if (flushing !== 1'b0 || dut.flush_cnt_r !== 2'd0) begin bad++; $display("FAIL freeze_resume got=%b/%0d exp=0/0", flushing, dut.flush_cnt_r); end
    rdy = 1'b0;
    #1;
    total++; if (launch !== 1'b0) begin bad++; $display("FAIL rdy_low_launch got=%b exp=0", launch); end
    tick();
    total++; if (dut.u_rs.count !== 5'd16 || credit_err !== 1'b0) begin bad++; $display("FAIL rdy_low_hold got=%0d/%b exp=16/0", dut.u_rs.count, credit_err); end
    rdy = 1'b1; IQ_head_valid = 1'b0;
  endtask

  // Release at full credit saturates and sets the sticky error
  task automatic test_credit_err();
    do_reset();
    RS_release = 1'b1; tick(); RS_release = 1'b0;
    total++; if (dut.u_rs.count !== 5'd16 || credit_err !== 1'b1) begin bad++; $display("FAIL overflow got=%0d/%b exp=16/1", dut.u_rs.count, credit_err); end
    ROB_roll_back_flag = 1'b1; tick(); ROB_roll_back_flag = 1'b0;
    tick(); tick(); tick();
    total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", credit_err); end
    do_reset();
    total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", credit_err); end
  endtask

  initial begin
    test_reset();
    test_rs_fill();
    test_lsb_launch();
    test_rollback();
    test_reload();
    test_rdy_freeze();
    test_credit_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
